gp_cmd_dispatch: RTL and testbench
==================================

# gp_cmd_dispatch

Parametrised graphics command processor that consumes a 32-bit command word stream from the DRAM command FIFO and dispatches fully assembled LINE, POLYLINE and FILL jobs to a bank of line engines and one frame filler. It sits between the command FIFO and the drawing engines, under CPU control via start/frame/interrupt registers. Unlike the previous processor, each job is delivered in one valid/ready beat, line jobs are spread round-robin over `NUM_LE` engines, and POLYLINE chains segments without re-sending shared points.

## Interface
- `NUM_LE`, 2: number of line engines, 1..8.
- `COORD_W`, 10: bits per X/Y coordinate; point = {X,Y}, 2*COORD_W bits.
- `CNT_W`, 16: POLYLINE point-count width.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `gp_start` in 1: one-cycle pulse; begin (or restart) command parsing.
- `gp_frame` in 32: frame base address; sampled on `gp_start`.
- `gp_irq` out 1: level interrupt; set on STOP.
- `gp_irq_ack` in 1: clears `gp_irq`.
- `gp_err` out 1: sticky; unknown opcode or POLYLINE count < 2; cleared by `gp_start`.
- `cmd_valid` in 1, `cmd_data` in 32, `cmd_ready` out 1: command word stream.
- `le_valid` out NUM_LE, `le_ready` in NUM_LE: per-engine job handshake.
- `le_color` out 32, `le_p0` out 2*COORD_W, `le_p1` out 2*COORD_W, `le_frame` out 32: shared job fields, valid for any `le_valid` bit.
- `ff_valid` out 1, `ff_ready` in 1, `ff_color` out 24, `ff_frame` out 32: fill job.

## Operation
- Word format: opcode `[31:24]`, color `[23:0]`; point words X = `[16+COORD_W-1:16]`, Y = `[COORD_W-1:0]`; count word N = `[CNT_W-1:0]`.
- Opcodes: 0x00 STOP, 0x01 LINE (hdr, p0, p1), 0x02 FILL (hdr), 0x03 POLYLINE (hdr, N, p0..pN-1).
- States: IDLE, HDR, CNT, PT0, PT1, DISP, PLNEXT.
- IDLE: `cmd_ready`=0; `gp_start` -> HDR, latch `gp_frame`.
- HDR: accept word. STOP -> set `gp_irq`, IDLE. FILL -> DISP(fill). LINE -> PT0. POLYLINE -> CNT. Unknown -> set `gp_err`, stay in HDR (word dropped).
- CNT: N<2 -> set `gp_err`, skip N points (N=0/1), then HDR. Else latch remaining = N-1 -> PT0.
- PT0 -> PT1 -> DISP(line).
- DISP(line): assert `le_valid[sel]`, where `sel` = first ready engine at or after round-robin pointer; wait for any ready engine. On handshake the pointer advances to sel+1 mod NUM_LE. LINE -> HDR. POLYLINE: remaining--; p0 <= p1; remaining==0 -> HDR, else PLNEXT.
- PLNEXT: accept one point into p1 -> DISP(line).
- DISP(fill): `ff_valid`=1 until `ff_ready`, then HDR.
- `cmd_ready`=1 only in HDR, CNT, PT0, PT1, PLNEXT.
- `le_color` = {8'h00, color}; frames = latched `gp_frame`.
- `gp_start` during HDR..PLNEXT: partial command discarded, next cycle HDR with new frame. During DISP: pending job completes (valid never withdrawn), then HDR with new frame. Also clears `gp_err` and `gp_irq`.
- `gp_irq` set and `gp_irq_ack` in same cycle: set wins.

## Timing
- Reset: state IDLE, all `*_valid`=0, `cmd_ready`=0, `gp_irq`=0, `gp_err`=0, rr pointer 0, all data outputs 0.
- All outputs registered; a word accepted at edge k updates state at k; job valid asserted in cycle after last word accepted.
- LINE latency: 3 accepted words + 1 cycle to `le_valid`. Throughput: one line per 4 cycles (LINE); one segment per 2 cycles (POLYLINE) with ready engines.
- Job fields stable while any valid is high; at most one `le_valid` bit high.
- Stalls (`cmd_valid`=0 or no engine ready) hold state indefinitely, no data loss.

## Structure
- Package `gp_pkg`: opcode constants, state enum, word field index macros shared with the command FIFO and software header.
- Sub-module `gp_rr_pick` (NUM_LE-wide round-robin first-ready selector: pointer, ready vector -> one-hot grant, any).

## Test plan
- LINE 0x01FF0000, 0x000A0014, 0x00640032 with NUM_LE=2, both ready -> `le_valid`=2'b01, color 0x00FF0000, p0 {10,20}, p1 {100,50}; next LINE goes to engine 1.
- POLYLINE count 4, points A,B,C,D -> three jobs A-B, B-C, C-D; `cmd_ready`=0 during each DISP.
- FILL 0x020000FF with `ff_ready` low 5 cycles -> `ff_valid` held 6 cycles, fields stable, then one beat.
- `le_ready`=2'b10 with pointer at 0 -> engine 1 selected; pointer becomes 0.
- Opcode 0x7F then STOP -> `gp_err`=1, `gp_irq`=1, IDLE; `gp_irq_ack` clears irq only.
- `gp_start` after LINE p0 accepted -> partial dropped, next LINE parses from HDR with new frame; `rst` mid-DISP -> all valids 0 next cycle.

Source files
------------

// File: rtl/gp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gp_pkg
// Description : Shared opcode values, command-word field positions and
//               parser state encoding for the graphics command dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package gp_pkg;

    // Command opcodes carried in the header word
    localparam logic [7:0] c_OP_STOP  = 8'h00;
    localparam logic [7:0] c_OP_LINE  = 8'h01;
    localparam logic [7:0] c_OP_FILL  = 8'h02;
    localparam logic [7:0] c_OP_PLINE = 8'h03;

    // Command word field positions
    localparam int c_OP_MSB   = 31;
    localparam int c_OP_LSB   = 24;
    localparam int c_COLOR_W  = 24;
    localparam int c_PT_X_LSB = 16;

    // Parser state encoding
    localparam int c_ST_W = 3;
    typedef logic [c_ST_W-1:0] gp_state_t;

    localparam gp_state_t c_ST_IDLE   = 3'd0;
    localparam gp_state_t c_ST_HDR    = 3'd1;
    localparam gp_state_t c_ST_CNT    = 3'd2;
    localparam gp_state_t c_ST_PT0    = 3'd3;
    localparam gp_state_t c_ST_PT1    = 3'd4;
    localparam gp_state_t c_ST_DISP   = 3'd5;
    localparam gp_state_t c_ST_PLNEXT = 3'd6;

    // States in which the parser consumes command words
    function automatic logic gp_accepts_words(input gp_state_t st);
        return (st == c_ST_HDR) || (st == c_ST_CNT) || (st == c_ST_PT0) ||
               (st == c_ST_PT1) || (st == c_ST_PLNEXT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/gp_cmd_dispatch_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : gp_rr_pick
// Description : Round-robin first-ready selector. Returns a one-hot grant for
//               the first requesting engine at or after the pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module gp_rr_pick #(
    parameter int NUM_LE = 2,
    parameter int PTR_W  = 1
) (
    input  logic [PTR_W-1:0]  ptr,
    input  logic [NUM_LE-1:0] req,
    output logic [NUM_LE-1:0] grant,
    output logic              any
);

    logic [2*NUM_LE-1:0] w_req_dbl;
    logic [NUM_LE-1:0]   w_rot;
    logic [NUM_LE-1:0]   w_low;
    logic [2*NUM_LE-1:0] w_low_dbl;

    // Rotate requests so the pointer lands on bit 0, keep the lowest set bit,
    // then rotate that single bit back into engine numbering.
    assign w_req_dbl = {req, req};
    assign w_rot     = NUM_LE'(w_req_dbl >> ptr);
    assign w_low     = w_rot & (~w_rot + NUM_LE'(1));
    assign w_low_dbl = {w_low, w_low};
    assign grant     = NUM_LE'(w_low_dbl >> (NUM_LE - int'(ptr)));
    assign any       = |req;

endmodule
`default_nettype wire

// File: rtl/gp_cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : gp_cmd_dispatch
// Description : Parses the 32-bit command stream into LINE / POLYLINE / FILL
//               jobs and hands each one over in a single valid/ready beat,
//               spreading line jobs round-robin over NUM_LE engines.
// Revision    : 1.0 - initial release
// ============================================================================
module gp_cmd_dispatch
    import gp_pkg::*;
#(
    parameter int NUM_LE  = 2,
    parameter int COORD_W = 10,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gp_start,
    input  logic [31:0]          gp_frame,
    output logic                 gp_irq,
    input  logic                 gp_irq_ack,
    output logic                 gp_err,
    input  logic                 cmd_valid,
    input  logic [31:0]          cmd_data,
    output logic                 cmd_ready,
    output logic [NUM_LE-1:0]    le_valid,
    input  logic [NUM_LE-1:0]    le_ready,
    output logic [31:0]          le_color,
    output logic [2*COORD_W-1:0] le_p0,
    output logic [2*COORD_W-1:0] le_p1,
    output logic [31:0]          le_frame,
    output logic                 ff_valid,
    input  logic                 ff_ready,
    output logic [23:0]          ff_color,
    output logic [31:0]          ff_frame
);

    localparam int c_PTR_W = (NUM_LE > 1) ? $clog2(NUM_LE) : 1;

    gp_state_t              r_state;
    logic                   r_cmd_ready;
    logic [NUM_LE-1:0]      r_le_valid;
    logic                   r_ff_valid;
    logic                   r_irq;
    logic                   r_err;
    logic [c_PTR_W-1:0]     r_ptr;
    logic [31:0]            r_frame;
    logic [31:0]            r_frame_pend;
    logic                   r_restart;
    logic [c_COLOR_W-1:0]   r_color;
    logic [2*COORD_W-1:0]   r_p0;
    logic [2*COORD_W-1:0]   r_p1;
    logic [CNT_W-1:0]       r_remaining;
    logic                   r_fill;
    logic                   r_poly;
    logic                   r_skip;

    gp_state_t              w_state_nxt;
    logic                   w_acc;
    logic [7:0]             w_op;
    logic [CNT_W-1:0]       w_cnt;
    logic [2*COORD_W-1:0]   w_point;
    logic                   w_le_hs;
    logic                   w_ff_hs;
    logic                   w_disp_done;
    logic                   w_last_seg;
    logic                   w_enter_disp;
    logic                   w_set_irq;
    logic                   w_set_err;
    logic [NUM_LE-1:0]      w_grant;
    logic                   w_any;
    logic [NUM_LE-1:0]      w_ptr_onehot;
    logic [c_PTR_W-1:0]     w_sel_idx;
    logic [c_PTR_W-1:0]     w_ptr_nxt;

    assign w_acc        = r_cmd_ready & cmd_valid;
    assign w_op         = cmd_data[c_OP_MSB:c_OP_LSB];
    assign w_cnt        = cmd_data[CNT_W-1:0];
    assign w_point      = {cmd_data[c_PT_X_LSB+COORD_W-1:c_PT_X_LSB], cmd_data[COORD_W-1:0]};
    assign w_le_hs      = |(r_le_valid & le_ready);
    assign w_ff_hs      = r_ff_valid & ff_ready;
    assign w_disp_done  = (r_state == c_ST_DISP) && (r_fill ? w_ff_hs : w_le_hs);
    assign w_last_seg   = (r_remaining == CNT_W'(1));
    assign w_enter_disp = (r_state != c_ST_DISP) && (w_state_nxt == c_ST_DISP);
    assign w_ptr_onehot = NUM_LE'(1) << r_ptr;

    assign w_set_irq = (r_state == c_ST_HDR) && w_acc && (w_op == c_OP_STOP);
    assign w_set_err = ((r_state == c_ST_HDR) && w_acc && (w_op > c_OP_PLINE)) ||
                       ((r_state == c_ST_CNT) && w_acc && (w_cnt < CNT_W'(2)));

    gp_rr_pick #(
        .NUM_LE (NUM_LE),
        .PTR_W  (c_PTR_W)
    ) u_rr_pick (
        .ptr   (r_ptr),
        .req   (le_ready),
        .grant (w_grant),
        .any   (w_any)
    );

    // Index of the engine currently offered a job, for pointer advance
    always_comb begin
        w_sel_idx = '0;
        for (int i = 0; i < NUM_LE; i++) begin
            if (r_le_valid[i]) begin
                w_sel_idx = c_PTR_W'(i);
            end
        end
    end

    assign w_ptr_nxt = (w_sel_idx == c_PTR_W'(NUM_LE - 1)) ? '0 : w_sel_idx + c_PTR_W'(1);

    // Parser next-state decision; gp_start always wins outside DISP
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (gp_start) w_state_nxt = c_ST_HDR;
            end
            c_ST_HDR: begin
                if (gp_start) begin
                    w_state_nxt = c_ST_HDR;
                end else if (w_acc) begin
                    case (w_op)
                        c_OP_STOP:  w_state_nxt = c_ST_IDLE;
                        c_OP_LINE:  w_state_nxt = c_ST_PT0;
                        c_OP_FILL:  w_state_nxt = c_ST_DISP;
                        c_OP_PLINE: w_state_nxt = c_ST_CNT;
                        default:    w_state_nxt = c_ST_HDR;
                    endcase
                end
            end
            c_ST_CNT: begin
                if (gp_start) begin
                    w_state_nxt = c_ST_HDR;
                end else if (w_acc) begin
                    // N=0 has no points to drop; N=1 drops one point in PT0
                    w_state_nxt = (w_cnt == '0) ? c_ST_HDR : c_ST_PT0;
                end
            end
            c_ST_PT0: begin
                if (gp_start) begin
                    w_state_nxt = c_ST_HDR;
                end else if (w_acc) begin
                    w_state_nxt = r_skip ? c_ST_HDR : c_ST_PT1;
                end
            end
            c_ST_PT1, c_ST_PLNEXT: begin
                if (gp_start) begin
                    w_state_nxt = c_ST_HDR;
                end else if (w_acc) begin
                    w_state_nxt = c_ST_DISP;
                end
            end
            c_ST_DISP: begin
                if (w_disp_done) begin
                    w_state_nxt = (r_fill || !r_poly || w_last_seg || r_restart || gp_start) ?
                                  c_ST_HDR : c_ST_PLNEXT;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Parser state, job fields and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_cmd_ready  <= 1'b0;
            r_le_valid   <= '0;
            r_ff_valid   <= 1'b0;
            r_irq        <= 1'b0;
            r_err        <= 1'b0;
            r_ptr        <= '0;
            r_frame      <= '0;
            r_frame_pend <= '0;
            r_restart    <= 1'b0;
            r_color      <= '0;
            r_p0         <= '0;
            r_p1         <= '0;
            r_remaining  <= '0;
            r_fill       <= 1'b0;
            r_poly       <= 1'b0;
            r_skip       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cmd_ready <= gp_accepts_words(w_state_nxt);

            // Interrupt and error flags; a new start clears both
            if (gp_start) begin
                r_irq <= 1'b0;
                r_err <= 1'b0;
            end else begin
                if (w_set_irq) begin
                    r_irq <= 1'b1;
                end else if (gp_irq_ack) begin
                    r_irq <= 1'b0;
                end
                if (w_set_err) begin
                    r_err <= 1'b1;
                end
            end

            // A start during DISP must not disturb the job on the bus, so the
            // new frame is parked until that job is taken.
            if (gp_start && ((r_state != c_ST_DISP) || w_disp_done)) begin
                r_frame   <= gp_frame;
                r_restart <= 1'b0;
            end else if (gp_start) begin
                r_frame_pend <= gp_frame;
                r_restart    <= 1'b1;
            end else if (w_disp_done && r_restart) begin
                r_frame   <= r_frame_pend;
                r_restart <= 1'b0;
            end

            // Word capture
            if (w_acc) begin
                case (r_state)
                    c_ST_HDR: begin
                        r_color <= cmd_data[c_COLOR_W-1:0];
                        r_fill  <= (w_op == c_OP_FILL);
                        r_poly  <= (w_op == c_OP_PLINE);
                        r_skip  <= 1'b0;
                    end
                    c_ST_CNT: begin
                        r_remaining <= w_cnt - CNT_W'(1);
                        r_skip      <= (w_cnt == CNT_W'(1));
                    end
                    c_ST_PT0:    r_p0 <= w_point;
                    c_ST_PT1:    r_p1 <= w_point;
                    c_ST_PLNEXT: r_p1 <= w_point;
                    default: ;
                endcase
            end

            // Line hand-off: advance pointer and chain polyline segments
            if ((r_state == c_ST_DISP) && !r_fill && w_le_hs) begin
                r_ptr <= w_ptr_nxt;
                if (r_poly) begin
                    r_p0        <= r_p1;
                    r_remaining <= r_remaining - CNT_W'(1);
                end
            end

            // Line valid: offered to the first ready engine, re-targeted while
            // the chosen engine is not ready, dropped after the hand-off.
            if (w_enter_disp && (r_state != c_ST_HDR)) begin
                r_le_valid <= w_any ? w_grant : w_ptr_onehot;
            end else if ((r_state == c_ST_DISP) && !r_fill && !w_disp_done) begin
                r_le_valid <= w_any ? w_grant : r_le_valid;
            end else begin
                r_le_valid <= '0;
            end

            // Fill valid: raised from the FILL header, held until taken
            r_ff_valid <= (w_enter_disp && (r_state == c_ST_HDR)) ||
                          ((r_state == c_ST_DISP) && r_fill && !w_disp_done);
        end
    end

    assign gp_irq    = r_irq;
    assign gp_err    = r_err;
    assign cmd_ready = r_cmd_ready;
    assign le_valid  = r_le_valid;
    assign le_color  = {8'h00, r_color};
    assign le_p0     = r_p0;
    assign le_p1     = r_p1;
    assign le_frame  = r_frame;
    assign ff_valid  = r_ff_valid;
    assign ff_color  = r_color;
    assign ff_frame  = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_gp_cmd_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_gp_cmd_dispatch
// Description : Self-checking bench for gp_cmd_dispatch: directed scenarios
//               followed by a random command program compared against a
//               job-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gp_cmd_dispatch;

    localparam int NLE = 2;

    typedef struct packed {
        logic        fill;
        logic [31:0] color;
        logic [19:0] p0;
        logic [19:0] p1;
        logic [31:0] frame;
    } job_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            gp_start;
    logic [31:0]     gp_frame;
    logic            gp_irq;
    logic            gp_irq_ack;
    logic            gp_err;
    logic            cmd_valid;
    logic [31:0]     cmd_data;
    logic            cmd_ready;
    logic [NLE-1:0]  le_valid;
    logic [NLE-1:0]  le_ready;
    logic [31:0]     le_color;
    logic [19:0]     le_p0;
    logic [19:0]     le_p1;
    logic [31:0]     le_frame;
    logic            ff_valid;
    logic            ff_ready;
    logic [23:0]     ff_color;
    logic [31:0]     ff_frame;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] wq[$];
    job_t        exp_q[$];
    logic [31:0] pw[8];
    logic [31:0] frm;
    logic [23:0] col;
    logic [7:0]  op;
    logic        exp_err;
    job_t        got;
    int          kind;
    int          npts;
    int          cyc;

    always #5 clk = ~clk;

    gp_cmd_dispatch #(
        .NUM_LE  (NLE),
        .COORD_W (10),
        .CNT_W   (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .gp_start   (gp_start),
        .gp_frame   (gp_frame),
        .gp_irq     (gp_irq),
        .gp_irq_ack (gp_irq_ack),
        .gp_err     (gp_err),
        .cmd_valid  (cmd_valid),
        .cmd_data   (cmd_data),
        .cmd_ready  (cmd_ready),
        .le_valid   (le_valid),
        .le_ready   (le_ready),
        .le_color   (le_color),
        .le_p0      (le_p0),
        .le_p1      (le_p1),
        .le_frame   (le_frame),
        .ff_valid   (ff_valid),
        .ff_ready   (ff_ready),
        .ff_color   (ff_color),
        .ff_frame   (ff_frame)
    );

    task automatic chk_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // point word -> {X,Y}
    function automatic logic [19:0] pt(input logic [31:0] w);
        return {w[25:16], w[9:0]};
    endfunction

    function automatic job_t mk_job(input logic f, input logic [31:0] c,
                                    input logic [19:0] a, input logic [19:0] b,
                                    input logic [31:0] fr);
        job_t j;
        j.fill = f; j.color = c; j.p0 = a; j.p1 = b; j.frame = fr;
        return j;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_data  = w;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        chk_val("send_ready", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic start_pulse(input logic [31:0] fr);
        gp_frame = fr;
        gp_start = 1'b1;
        tick();
        gp_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; gp_start = 1'b0; gp_frame = '0; gp_irq_ack = 1'b0;
        cmd_valid = 1'b0; cmd_data = '0; le_ready = '0; ff_ready = 1'b0;
        repeat (3) tick();
        chk_val("rst_cmd_ready", cmd_ready, 0);
        chk_val("rst_le_valid", le_valid, 0);
        chk_val("rst_ff_valid", ff_valid, 0);
        chk_val("rst_irq", gp_irq, 0);
        chk_val("rst_err", gp_err, 0);
        chk_val("rst_data", {le_color, le_p0, le_p1, le_frame}, 0);
        rst = 1'b0;
        tick();
        chk_val("idle_cmd_ready", cmd_ready, 0);

        // basic LINE, engine 0 first
        start_pulse(32'h1000_0000);
        le_ready = 2'b11;
        chk_val("start_ready", cmd_ready, 1);
        send(32'h01FF_0000); send(32'h000A_0014); send(32'h0064_0032);
        chk_val("line_valid", le_valid, 2'b01);
        chk_val("line_color", le_color, 32'h00FF_0000);
        chk_val("line_p0", le_p0, {10'd10, 10'd20});
        chk_val("line_p1", le_p1, {10'd100, 10'd50});
        chk_val("line_frame", le_frame, 32'h1000_0000);
        chk_val("line_busy", cmd_ready, 0);
        tick();
        chk_val("line_done", le_valid, 0);

        // second LINE goes to engine 1
        send(32'h0112_3456); send(32'h0001_0002); send(32'h0003_0004);
        chk_val("rr_next", le_valid, 2'b10);
        tick();

        // pointer at 0, only engine 1 ready
        le_ready = 2'b10;
        send(32'h0100_0001); send(32'h0001_0001); send(32'h0002_0002);
        chk_val("rr_skip", le_valid, 2'b10);
        tick();
        le_ready = 2'b11;
        send(32'h0100_0002); send(32'h0001_0001); send(32'h0002_0002);
        chk_val("rr_wrap", le_valid, 2'b01);
        tick();

        // POLYLINE of four points -> three chained segments
        send(32'h03AB_CDEF); send(32'h0000_0004);
        send(32'h0005_0006); send(32'h0007_0008);
        chk_val("pl_seg0", {le_p0, le_p1}, {pt(32'h0005_0006), pt(32'h0007_0008)});
        chk_val("pl_seg0_color", le_color, 32'h00AB_CDEF);
        chk_val("pl_seg0_busy", cmd_ready, 0);
        tick();
        chk_val("pl_next_ready", cmd_ready, 1);
        send(32'h0009_000A);
        chk_val("pl_seg1", {le_p0, le_p1}, {pt(32'h0007_0008), pt(32'h0009_000A)});
        chk_val("pl_seg1_busy", cmd_ready, 0);
        tick();
        send(32'h000B_000C);
        chk_val("pl_seg2", {le_p0, le_p1}, {pt(32'h0009_000A), pt(32'h000B_000C)});
        tick();
        chk_val("pl_end_valid", le_valid, 0);
        chk_val("pl_end_ready", cmd_ready, 1);

        // FILL held six cycles while ff_ready is low for five
        ff_ready = 1'b0;
        send(32'h0200_00FF);
        for (int i = 0; i < 6; i++) begin
            chk_val("fill_valid", ff_valid, 1);
            chk_val("fill_fields", {ff_color, ff_frame}, {24'h0000FF, 32'h1000_0000});
            if (i == 5) ff_ready = 1'b1;
            tick();
        end
        chk_val("fill_done", ff_valid, 0);

        // unknown opcode then STOP
        send(32'h7F00_0000);
        chk_val("bad_op_err", gp_err, 1);
        send(32'h0000_0000);
        chk_val("stop_irq", gp_irq, 1);
        chk_val("stop_idle", cmd_ready, 0);
        gp_irq_ack = 1'b1;
        tick();
        gp_irq_ack = 1'b0;
        chk_val("ack_irq", gp_irq, 0);
        chk_val("ack_err_kept", gp_err, 1);

        // restart mid-command
        start_pulse(32'h2000_0000);
        chk_val("start_clr_err", gp_err, 0);
        send(32'h0111_1111); send(32'h0007_0008);
        start_pulse(32'h3000_0000);
        chk_val("restart_ready", cmd_ready, 1);
        send(32'h0122_2222); send(32'h0011_0012); send(32'h0013_0014);
        chk_val("restart_job",
                {le_color, le_p0, le_p1, le_frame},
                {32'h0022_2222, pt(32'h0011_0012), pt(32'h0013_0014), 32'h3000_0000});
        tick();

        // stall, then reset in DISP
        le_ready = 2'b00;
        send(32'h0100_0003); send(32'h0001_0001); send(32'h0002_0002);
        chk_val("stall_valid", |le_valid, 1);
        tick();
        chk_val("stall_hold", |le_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_val("rst_disp_valid", le_valid, 0);
        chk_val("rst_disp_ready", cmd_ready, 0);

        // random program against the job-level model
        frm = $urandom;
        exp_err = 1'b0;
        for (int k = 0; k < 30; k++) begin
            kind = $urandom_range(0, 9);
            col  = 24'($urandom);
            if (kind <= 3) begin
                pw[0] = $urandom; pw[1] = $urandom;
                wq.push_back({8'h01, col}); wq.push_back(pw[0]); wq.push_back(pw[1]);
                exp_q.push_back(mk_job(1'b0, {8'h00, col}, pt(pw[0]), pt(pw[1]), frm));
            end else if (kind <= 5) begin
                wq.push_back({8'h02, col});
                exp_q.push_back(mk_job(1'b1, {8'h00, col}, '0, '0, frm));
            end else if (kind <= 7) begin
                npts = $urandom_range(2, 5);
                wq.push_back({8'h03, col});
                wq.push_back({16'($urandom), 16'(npts)});
                for (int i = 0; i < npts; i++) begin
                    pw[i] = $urandom;
                    wq.push_back(pw[i]);
                end
                for (int i = 0; i < npts - 1; i++)
                    exp_q.push_back(mk_job(1'b0, {8'h00, col}, pt(pw[i]), pt(pw[i+1]), frm));
            end else if (kind == 8) begin
                op = 8'($urandom_range(4, 255));
                wq.push_back({op, col});
                exp_err = 1'b1;
            end else begin
                npts = $urandom_range(0, 1);
                wq.push_back({8'h03, col});
                wq.push_back({16'($urandom), 16'(npts)});
                for (int i = 0; i < npts; i++) wq.push_back($urandom);
                exp_err = 1'b1;
            end
        end
        wq.push_back(32'h0000_0000);

        le_ready = '0;
        ff_ready = 1'b0;
        start_pulse(frm);
        cyc = 0;
        while (cyc < 20000 && !(wq.size() == 0 && exp_q.size() == 0 && gp_irq)) begin
            cmd_valid = (wq.size() > 0) && ($urandom_range(0, 3) != 0);
            if (wq.size() > 0) cmd_data = wq[0];
            le_ready = NLE'($urandom);
            ff_ready = 1'($urandom);
            @(negedge clk);
            if (cmd_valid && cmd_ready) void'(wq.pop_front());
            if (le_valid != '0) chk_val("rnd_onehot", $countones(le_valid) <= 1, 1);
            for (int i = 0; i < NLE; i++) begin
                if (le_valid[i] && le_ready[i]) begin
                    got = mk_job(1'b0, le_color, le_p0, le_p1, le_frame);
                    if (exp_q.size() == 0) chk_val("rnd_extra_job", exp_q.size(), 1);
                    else chk_val("rnd_line_job", got, exp_q.pop_front());
                end
            end
            if (ff_valid && ff_ready) begin
                got = mk_job(1'b1, {8'h00, ff_color}, '0, '0, ff_frame);
                if (exp_q.size() == 0) chk_val("rnd_extra_job", exp_q.size(), 1);
                else chk_val("rnd_fill_job", got, exp_q.pop_front());
            end
            tick();
            cyc++;
        end
        cmd_valid = 1'b0;
        chk_val("rnd_words_left", wq.size(), 0);
        chk_val("rnd_jobs_left", exp_q.size(), 0);
        chk_val("rnd_irq", gp_irq, 1);
        chk_val("rnd_err", gp_err, exp_err);
        chk_val("rnd_idle", cmd_ready, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
